// File: rtl/dect_pkg.sv
// rtl/dect_pkg.sv - shared types, defaults and width helper for the detector scheduler
package dect_pkg;

   localparam int SYM_W_DEF = 3;
   localparam int RES_W_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int cw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
   import dect_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = cw(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx
);

   int   j;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(last_grant) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/dect_sched.sv
// rtl/dect_sched.sv - time-shares one sequence detector among NREQ symbol requesters
module dect_sched
   import dect_pkg::*;
#(
   parameter  int NREQ      = 4,
   parameter  int BURST_LEN = 8,
   parameter  int DET_LAT   = 1,
   parameter  int SYM_W     = SYM_W_DEF,
   parameter  int RES_W     = RES_W_DEF,
   localparam int IDW       = cw(NREQ),
   localparam int SCW       = cw(BURST_LEN + 1),
   localparam int LCW       = cw(DET_LAT + 1)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*SYM_W-1:0] sym_in,
   input  logic [NREQ-1:0]       sym_valid,
   output logic [NREQ-1:0]       sym_ack,
   output logic [NREQ-1:0]       gnt,
   output logic                  det_clr,
   output logic                  det_en,
   output logic [SYM_W-1:0]      det_inp,
   input  logic [RES_W-1:0]      det_outp,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [RES_W-1:0]      rsp_code,
   input  logic                  rsp_ready
);

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [IDW-1:0]   arb_idx;
   logic [NREQ-1:0]  arb_gnt;
   logic [SCW-1:0]   sym_cnt;
   logic [LCW-1:0]   lat_cnt;
   logic [SYM_W-1:0] sym_sel;
   logic             aborting;
   logic             take;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req        (req),
      .last_grant (last_grant),
      .gnt        (arb_gnt),
      .idx        (arb_idx)
   );

   always_comb begin
      sym_sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) sym_sel = sym_sel | sym_in[i*SYM_W +: SYM_W];
   end

   assign sym_ack  = (state == ST_STREAM) ? (gnt & sym_valid & req) : '0;
   assign aborting = (state == ST_STREAM) && ((gnt & req) == '0);
   assign take     = |sym_ack;
   assign det_clr  = (state == ST_CLEAR);
   assign det_en   = take;
   assign det_inp  = take ? sym_sel : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         gnt        <= '0;
         last_grant <= IDW'(NREQ - 1);
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_code   <= '0;
         sym_cnt    <= '0;
         lat_cnt    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (|req) begin
               gnt        <= arb_gnt;
               rsp_id     <= arb_idx;
               last_grant <= arb_idx;
               sym_cnt    <= '0;
               state      <= ST_CLEAR;
            end
            ST_CLEAR: state <= ST_STREAM;
            // An abort leaves last_grant on the aborted requester so rotation continues past it.
            ST_STREAM: if (aborting) begin
               gnt   <= '0;
               state <= ST_IDLE;
            end else if (take) begin
               if (sym_cnt < SCW'(BURST_LEN)) sym_cnt <= sym_cnt + SCW'(1);
               if (sym_cnt == SCW'(BURST_LEN - 1)) begin
                  lat_cnt <= '0;
                  state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: if (lat_cnt == LCW'(DET_LAT - 1)) begin
               rsp_code  <= det_outp;
               rsp_valid <= 1'b1;
               gnt       <= '0;
               state     <= ST_RESP;
            end else if (lat_cnt < LCW'(DET_LAT)) begin
               lat_cnt <= lat_cnt + LCW'(1);
            end
            ST_RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dect_sched.sv
// tb/tb_dect_sched.sv - directed table-driven bench for dect_sched
module tb_dect_sched;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  req, sym_valid, sym_ack, gnt;
   logic [11:0] sym_in;
   logic        det_clr, det_en, rsp_valid, rsp_ready;
   logic [2:0]  det_inp;
   logic [1:0]  det_outp, rsp_id, rsp_code;

   logic [3:0]  req2, sym_valid2, sym_ack2, gnt2;
   logic [11:0] sym_in2;
   logic        det_clr2, det_en2, rsp_valid2, rsp_ready2;
   logic [2:0]  det_inp2;
   logic [1:0]  det_outp2, rsp_id2, rsp_code2;

   logic [1:0]  acc, det_xor;
   logic [2:0]  pipe2;
   int          nvec = 0;
   int          nerr = 0;

   dect_sched u_dut (
      .clk(clk), .rst(rst), .req(req), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ack(sym_ack), .gnt(gnt), .det_clr(det_clr), .det_en(det_en),
      .det_inp(det_inp), .det_outp(det_outp), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_code(rsp_code), .rsp_ready(rsp_ready)
   );

   dect_sched #(.BURST_LEN(1), .DET_LAT(3)) u_dut2 (
      .clk(clk), .rst(rst), .req(req2), .sym_in(sym_in2), .sym_valid(sym_valid2),
      .sym_ack(sym_ack2), .gnt(gnt2), .det_clr(det_clr2), .det_en(det_en2),
      .det_inp(det_inp2), .det_outp(det_outp2), .rsp_valid(rsp_valid2),
      .rsp_id(rsp_id2), .rsp_code(rsp_code2), .rsp_ready(rsp_ready2)
   );

   // Detector stand-ins: sum of symbols mod 4 (latency 1), and a 3-cycle marker.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc   <= 2'b00;
         pipe2 <= 3'b000;
      end else begin
         if (det_clr) acc <= 2'b00;
         else if (det_en) acc <= acc + det_inp[1:0];
         pipe2 <= {pipe2[1:0], det_en2};
      end
   end
   assign det_outp  = acc ^ det_xor;
   assign det_outp2 = pipe2[2] ? 2'b01 : 2'b10;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] vpat;
      logic [23:0] syms;
      logic [1:0]  xr;
      int          rdy_delay;
      int          exp_id;
      logic [1:0]  exp_code;
   } vec_t;

   vec_t tv[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic run_burst(input vec_t v);
      int c = 0, k = 0, clr_n = 0, rv_n = 0;
      int gnt_cyc = -1, last_ack = -1, rsp_cyc = -1;
      logic [3:0] gfirst = '0;
      logic bad_ack = 0, bad_inp = 0, unstable = 0, done = 0;
      logic [1:0] id0 = '0, code0 = '0;
      logic [2:0] cur;
      while (!done && c < 200) begin
         @(posedge clk); #1;
         req     = v.req;
         det_xor = v.xr;
         cur     = (k < 8) ? v.syms[k*3 +: 3] : 3'd0;
         for (int i = 0; i < 4; i++) begin
            sym_in[i*3 +: 3] = (i == v.exp_id) ? cur : 3'd7;
            sym_valid[i]     = (i == v.exp_id) ? v.vpat[c % 16] : 1'b1;
         end
         rsp_ready = (v.rdy_delay == 0) || (rv_n >= v.rdy_delay);
         @(negedge clk);
         if (gnt != 4'b0 && gnt_cyc < 0) begin
            gnt_cyc = c;
            gfirst  = gnt;
         end
         if (det_clr) clr_n++;
         if ((sym_ack & ~(4'b0001 << v.exp_id)) != 4'b0) bad_ack = 1;
         if (det_en) begin
            if (det_inp !== cur || !sym_ack[v.exp_id]) bad_inp = 1;
            k++;
            last_ack = c;
         end else if (det_inp !== 3'd0) begin
            bad_inp = 1;
         end
         if (rsp_valid) begin
            if (rv_n == 0) begin
               rsp_cyc = c;
               id0     = rsp_id;
               code0   = rsp_code;
            end else if (rsp_id !== id0 || rsp_code !== code0) begin
               unstable = 1;
            end
            rv_n++;
            if (rsp_ready) done = 1;
         end
         c++;
      end
      chk("burst_done", done, 1);
      chk("gnt_onehot", gfirst, 4'b0001 << v.exp_id);
      chk("gnt_latency", gnt_cyc, 1);
      chk("clr_pulses", clr_n, 1);
      chk("ack_count", k, 8);
      chk("foreign_ack", bad_ack, 0);
      chk("det_inp", bad_inp, 0);
      chk("rsp_id", id0, v.exp_id);
      chk("rsp_code", code0, v.exp_code);
      chk("rsp_latency", rsp_cyc - last_ack, 2);
      chk("rsp_hold", unstable, 0);
      chk("rsp_wait", rv_n, v.rdy_delay + 1);
   endtask

   initial begin
      int n, cyc, ack_c, rsp_c;
      logic saw_rsp;

      tv[0] = '{req:4'b0001, vpat:16'hFFFF, syms:24'o11111111, xr:2'b10, rdy_delay:0, exp_id:0, exp_code:2'b10};
      tv[1] = '{req:4'b1011, vpat:16'hFFFF, syms:24'o21234567, xr:2'b00, rdy_delay:0, exp_id:1, exp_code:2'b10};
      tv[2] = '{req:4'b1011, vpat:16'hFFFF, syms:24'o33333333, xr:2'b01, rdy_delay:0, exp_id:3, exp_code:2'b01};
      tv[3] = '{req:4'b1011, vpat:16'hFFFF, syms:24'o10000002, xr:2'b00, rdy_delay:0, exp_id:0, exp_code:2'b11};
      tv[4] = '{req:4'b0010, vpat:16'h9999, syms:24'o07654321, xr:2'b11, rdy_delay:5, exp_id:1, exp_code:2'b11};

      req = '0; sym_valid = '0; sym_in = '0; rsp_ready = 1'b0; det_xor = '0;
      req2 = '0; sym_valid2 = '0; sym_in2 = '0; rsp_ready2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {gnt, sym_ack, det_clr, det_en, det_inp, rsp_valid, rsp_id, rsp_code}, 0);
      rst = 1'b1;

      for (int t = 0; t < 5; t++) run_burst(tv[t]);

      // Abort: requester 2 drops req after three accepted symbols.
      @(posedge clk); #1;
      req = 4'b1100; sym_valid = 4'b1111; sym_in = 12'o7654; rsp_ready = 1'b1;
      n = 0; cyc = 0; saw_rsp = 0;
      while (n < 3 && cyc < 50) begin
         @(negedge clk);
         if (sym_ack[2]) n++;
         if (rsp_valid) saw_rsp = 1;
         cyc++;
      end
      chk("abort_acks", n, 3);
      @(posedge clk); #1;
      req = 4'b1000;
      @(negedge clk);
      chk("abort_no_ack", sym_ack, 4'b0000);
      @(negedge clk);
      chk("abort_idle", {gnt, det_en, rsp_valid}, 0);
      @(negedge clk);
      chk("abort_next_gnt", gnt, 4'b1000);
      if (rsp_valid) saw_rsp = 1;
      chk("abort_no_rsp", saw_rsp, 0);

      // Asynchronous reset while requester 3 is streaming.
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_stream", det_en, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", {gnt, sym_ack, det_clr, det_en, det_inp, rsp_valid, rsp_id, rsp_code}, 0);
      #9;
      rst = 1'b1;
      req = 4'b1111;
      @(negedge clk);
      chk("post_reset_no_gnt", gnt, 4'b0000);
      @(negedge clk);
      chk("post_reset_gnt", gnt, 4'b0001);
      req = 4'b0000;

      // Single-symbol burst with three cycles of detector latency.
      @(posedge clk); #1;
      req2 = 4'b0001; sym_valid2 = 4'b1111; sym_in2 = 12'o1111;
      n = 0; cyc = 0; ack_c = -1; rsp_c = -1;
      while (rsp_c < 0 && cyc < 40) begin
         @(negedge clk);
         if (det_en2) begin
            n++;
            ack_c = cyc;
         end
         if (rsp_valid2) rsp_c = cyc;
         cyc++;
      end
      chk("b1_acks", n, 1);
      chk("b1_rsp_latency", rsp_c - ack_c, 4);
      chk("b1_rsp_id", rsp_id2, 0);
      chk("b1_rsp_code", rsp_code2, 2'b01);
      req2 = 4'b0000;
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
